// File: rtl/ioc_cmd_master.sv
// ioc_cmd_master
//
// Initiator side of the IOC register bus. Decodes two-byte transactions
// arriving from the SPI byte deserializer into module selects, an IOC
// address and fetch/load strobes. For reads it captures the addressed
// module's returned byte and hands it back to the SPI shifter.
//
// Ports:
//   i_sys_clk       system clock
//   i_rst_b         asynchronous active-low reset
//   i_frame_active  SPI frame active, synchronized to i_sys_clk
//   i_rx_byte       received SPI byte
//   i_rx_valid      one-cycle strobe qualifying i_rx_byte
//   o_tx_byte       read data for the SPI shifter
//   o_tx_valid      one-cycle strobe, o_tx_byte updated
//   o_ioc           IOC address to modules
//   o_data_out      write data to modules
//   o_cs            one-hot module select
//   o_fetch_cmd     read strobe
//   o_load_cmd      write strobe
//   i_data_in       module read-back buses, module k at [8k+7:8k]
//   o_busy          high whenever the FSM is not idle
//   o_overrun       sticky, byte arrived during a strobe sequence

module ioc_cmd_master #(
    parameter int          NUM_MODULES  = 4,
    parameter logic [7:0]  INVALID_READ = 8'hFF
) (
    input  logic                       i_sys_clk,
    input  logic                       i_rst_b,
    input  logic                       i_frame_active,
    input  logic [7:0]                 i_rx_byte,
    input  logic                       i_rx_valid,
    output logic [7:0]                 o_tx_byte,
    output logic                       o_tx_valid,
    output logic [4:0]                 o_ioc,
    output logic [7:0]                 o_data_out,
    output logic [NUM_MODULES-1:0]     o_cs,
    output logic                       o_fetch_cmd,
    output logic                       o_load_cmd,
    input  logic [8*NUM_MODULES-1:0]   i_data_in,
    output logic                       o_busy,
    output logic                       o_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_STROBE,
        S_RD_CAPTURE,
        S_RD_RETURN,
        S_WAIT_DUMMY,
        S_WAIT_WDATA,
        S_WR_STROBE
    } state_t;

    state_t     state;
    logic [1:0] mod_idx;
    logic       dummy_seen;
    logic       frame_d;
    logic [7:0] rd_byte;
    logic       rx_take;

    // Module indices beyond NUM_MODULES decode to no select at all, which
    // is how strobes to absent modules are suppressed.
    function automatic logic [NUM_MODULES-1:0] decode_cs(input logic [1:0] m);
        logic [NUM_MODULES-1:0] cs;
        cs = '0;
        for (int k = 0; k < NUM_MODULES; k++) begin
            if (m == 2'(k)) begin
                cs[k] = 1'b1;
            end
        end
        return cs;
    endfunction

    function automatic logic mod_present(input logic [1:0] m);
        return int'(m) < NUM_MODULES;
    endfunction

    // Bytes are only meaningful inside an active frame.
    assign rx_take = i_rx_valid && i_frame_active;

    // Read-back mux; absent modules return the INVALID_READ pattern.
    always_comb begin
        rd_byte = INVALID_READ;
        for (int k = 0; k < NUM_MODULES; k++) begin
            if (mod_idx == 2'(k)) begin
                rd_byte = i_data_in[8*k +: 8];
            end
        end
    end

    // Transaction FSM. Every output is registered and is assigned on the
    // same edge that enters the state it belongs to, so the strobes line up
    // with the state rather than trailing it by a cycle. Strobes default to
    // low each cycle so they can only ever last one cycle. A dropped frame
    // forces idle and kills any strobe that would otherwise be issued.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state       <= S_IDLE;
            mod_idx     <= 2'd0;
            dummy_seen  <= 1'b0;
            frame_d     <= 1'b0;
            o_tx_byte   <= 8'h00;
            o_tx_valid  <= 1'b0;
            o_ioc       <= 5'd0;
            o_data_out  <= 8'h00;
            o_cs        <= '0;
            o_fetch_cmd <= 1'b0;
            o_load_cmd  <= 1'b0;
            o_busy      <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            frame_d     <= i_frame_active;
            o_tx_valid  <= 1'b0;
            o_cs        <= '0;
            o_fetch_cmd <= 1'b0;
            o_load_cmd  <= 1'b0;

            if (i_frame_active && !frame_d) begin
                o_overrun <= 1'b0;
            end

            if (!i_frame_active) begin
                state      <= S_IDLE;
                o_busy     <= 1'b0;
                dummy_seen <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rx_take) begin
                            mod_idx    <= i_rx_byte[6:5];
                            o_ioc      <= i_rx_byte[4:0];
                            dummy_seen <= 1'b0;
                            o_busy     <= 1'b1;
                            if (i_rx_byte[7]) begin
                                state <= S_WAIT_WDATA;
                            end else begin
                                state       <= S_RD_STROBE;
                                o_cs        <= decode_cs(i_rx_byte[6:5]);
                                o_fetch_cmd <= mod_present(i_rx_byte[6:5]);
                            end
                        end
                    end

                    S_RD_STROBE: begin
                        if (rx_take) begin
                            o_overrun  <= 1'b1;
                            dummy_seen <= 1'b1;
                        end
                        state <= S_RD_CAPTURE;
                    end

                    // The module latched its data on the previous edge, so
                    // the read-back bus is stable here.
                    S_RD_CAPTURE: begin
                        if (rx_take) begin
                            o_overrun  <= 1'b1;
                            dummy_seen <= 1'b1;
                        end
                        o_tx_byte  <= rd_byte;
                        o_tx_valid <= 1'b1;
                        state      <= S_RD_RETURN;
                    end

                    // A byte that arrived during the read sequence already
                    // served as the dummy, so skip waiting for another.
                    S_RD_RETURN: begin
                        if (rx_take) begin
                            o_overrun <= 1'b1;
                        end
                        if (rx_take || dummy_seen) begin
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            state <= S_WAIT_DUMMY;
                        end
                    end

                    S_WAIT_DUMMY: begin
                        if (rx_take) begin
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                        end
                    end

                    S_WAIT_WDATA: begin
                        if (rx_take) begin
                            o_data_out <= i_rx_byte;
                            o_cs       <= decode_cs(mod_idx);
                            o_load_cmd <= mod_present(mod_idx);
                            state      <= S_WR_STROBE;
                        end
                    end

                    S_WR_STROBE: begin
                        if (rx_take) begin
                            o_overrun <= 1'b1;
                        end
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end

                    default: begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ioc_cmd_master.sv
// tb_ioc_cmd_master
//
// Directed bench for ioc_cmd_master. A four-module instance carries most
// of the traffic; a three-module instance shares the same stimulus so that
// a read of module index 3 exercises the absent-module path.

module tb_ioc_cmd_master;

    logic        i_sys_clk;
    logic        i_rst_b;
    logic        i_frame_active;
    logic [7:0]  i_rx_byte;
    logic        i_rx_valid;
    logic [31:0] i_data_in;
    logic [23:0] i_data_in3;

    logic [7:0]  o_tx_byte,  o_tx_byte3;
    logic        o_tx_valid, o_tx_valid3;
    logic [4:0]  o_ioc,      o_ioc3;
    logic [7:0]  o_data_out, o_data_out3;
    logic [3:0]  o_cs;
    logic [2:0]  o_cs3;
    logic        o_fetch_cmd, o_fetch_cmd3;
    logic        o_load_cmd,  o_load_cmd3;
    logic        o_busy,      o_busy3;
    logic        o_overrun,   o_overrun3;

    int total;
    int bad;

    ioc_cmd_master #(.NUM_MODULES(4), .INVALID_READ(8'hFF)) dut (
        .i_sys_clk      (i_sys_clk),
        .i_rst_b        (i_rst_b),
        .i_frame_active (i_frame_active),
        .i_rx_byte      (i_rx_byte),
        .i_rx_valid     (i_rx_valid),
        .o_tx_byte      (o_tx_byte),
        .o_tx_valid     (o_tx_valid),
        .o_ioc          (o_ioc),
        .o_data_out     (o_data_out),
        .o_cs           (o_cs),
        .o_fetch_cmd    (o_fetch_cmd),
        .o_load_cmd     (o_load_cmd),
        .i_data_in      (i_data_in),
        .o_busy         (o_busy),
        .o_overrun      (o_overrun)
    );

    ioc_cmd_master #(.NUM_MODULES(3), .INVALID_READ(8'hFF)) dut3 (
        .i_sys_clk      (i_sys_clk),
        .i_rst_b        (i_rst_b),
        .i_frame_active (i_frame_active),
        .i_rx_byte      (i_rx_byte),
        .i_rx_valid     (i_rx_valid),
        .o_tx_byte      (o_tx_byte3),
        .o_tx_valid     (o_tx_valid3),
        .o_ioc          (o_ioc3),
        .o_data_out     (o_data_out3),
        .o_cs           (o_cs3),
        .o_fetch_cmd    (o_fetch_cmd3),
        .o_load_cmd     (o_load_cmd3),
        .i_data_in      (i_data_in3),
        .o_busy         (o_busy3),
        .o_overrun      (o_overrun3)
    );

    initial i_sys_clk = 1'b0;
    always #5 i_sys_clk = ~i_sys_clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_output(input string tag, input logic [31:0] got,
                                input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where outputs are stable.
    task automatic tick();
        @(posedge i_sys_clk);
        #1;
    endtask

    // Present one byte for exactly one cycle; returns in the following cycle.
    task automatic apply_stimulus(input logic [7:0] b);
        i_rx_byte  = b;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        i_rst_b        = 1'b0;
        i_frame_active = 1'b0;
        i_rx_byte      = 8'h00;
        i_rx_valid     = 1'b0;
        i_data_in      = {8'h44, 8'h33, 8'h22, 8'h01};
        i_data_in3     = {8'h77, 8'h66, 8'h55};

        tick();
        tick();
        check_output("rst_cs",      {28'd0, o_cs},      32'h0);
        check_output("rst_tx_byte", {24'd0, o_tx_byte}, 32'h00);
        check_output("rst_busy",    {31'd0, o_busy},    32'h0);
        check_output("rst_overrun", {31'd0, o_overrun}, 32'h0);
        i_rst_b = 1'b1;
        tick();

        // Read m=0 ioc=1
        i_frame_active = 1'b1;
        tick();
        apply_stimulus(8'h01);
        check_output("rd_cs_c1",    {28'd0, o_cs},        32'h1);
        check_output("rd_fetch_c1", {31'd0, o_fetch_cmd}, 32'h1);
        check_output("rd_ioc",      {27'd0, o_ioc},       32'h1);
        tick();
        check_output("rd_cs_c2",    {28'd0, o_cs},        32'h0);
        check_output("rd_fetch_c2", {31'd0, o_fetch_cmd}, 32'h0);
        check_output("rd_txv_c2",   {31'd0, o_tx_valid},  32'h0);
        tick();
        check_output("rd_txv_c3",   {31'd0, o_tx_valid},  32'h1);
        check_output("rd_tx_c3",    {24'd0, o_tx_byte},   32'h01);
        tick();
        check_output("rd_txv_c4",   {31'd0, o_tx_valid},  32'h0);
        check_output("rd_busy_c4",  {31'd0, o_busy},      32'h1);
        apply_stimulus(8'h00);
        check_output("rd_dummy_idle", {31'd0, o_busy},    32'h0);

        // Write m=1 ioc=4 data A5
        apply_stimulus(8'hA4);
        check_output("wr_cmd_load", {31'd0, o_load_cmd},  32'h0);
        check_output("wr_cmd_cs",   {28'd0, o_cs},        32'h0);
        check_output("wr_cmd_busy", {31'd0, o_busy},      32'h1);
        apply_stimulus(8'hA5);
        check_output("wr_cs",       {28'd0, o_cs},        32'h2);
        check_output("wr_load",     {31'd0, o_load_cmd},  32'h1);
        check_output("wr_fetch",    {31'd0, o_fetch_cmd}, 32'h0);
        check_output("wr_ioc",      {27'd0, o_ioc},       32'h4);
        check_output("wr_data",     {24'd0, o_data_out},  32'hA5);
        tick();
        check_output("wr_cs_c2",    {28'd0, o_cs},        32'h0);
        check_output("wr_load_c2",  {31'd0, o_load_cmd},  32'h0);
        check_output("wr_busy_c2",  {31'd0, o_busy},      32'h0);
        check_output("wr_data_hold", {24'd0, o_data_out}, 32'hA5);

        // Read of absent module index 3 on the three-module instance
        apply_stimulus(8'h62);
        check_output("inv_cs",      {29'd0, o_cs3},        32'h0);
        check_output("inv_fetch",   {31'd0, o_fetch_cmd3}, 32'h0);
        check_output("inv_busy",    {31'd0, o_busy3},      32'h1);
        check_output("inv_ioc",     {27'd0, o_ioc3},       32'h2);
        check_output("m3_cs_4mod",  {28'd0, o_cs},         32'h8);
        tick();
        tick();
        check_output("inv_txv",     {31'd0, o_tx_valid3},  32'h1);
        check_output("inv_tx",      {24'd0, o_tx_byte3},   32'hFF);
        check_output("m3_tx_4mod",  {24'd0, o_tx_byte},    32'h44);
        tick();
        apply_stimulus(8'h00);
        check_output("inv_idle",    {31'd0, o_busy3},      32'h0);

        // Abort a pending write by dropping the frame
        apply_stimulus(8'h84);
        i_frame_active = 1'b0;
        i_rx_byte      = 8'h99;
        i_rx_valid     = 1'b1;
        tick();
        i_rx_valid = 1'b0;
        check_output("abort_busy",  {31'd0, o_busy},      32'h0);
        check_output("abort_load",  {31'd0, o_load_cmd},  32'h0);
        tick();
        check_output("abort_load2", {31'd0, o_load_cmd},  32'h0);
        check_output("abort_data",  {24'd0, o_data_out},  32'hA5);
        i_frame_active = 1'b1;
        tick();
        apply_stimulus(8'h21);
        check_output("post_abort_cs", {28'd0, o_cs},      32'h2);
        tick();
        tick();
        check_output("post_abort_tx", {24'd0, o_tx_byte}, 32'h22);
        check_output("post_abort_txv", {31'd0, o_tx_valid}, 32'h1);
        tick();
        apply_stimulus(8'h00);

        // Burst in a fresh frame: read with early byte (overrun), then write
        i_frame_active = 1'b0;
        tick();
        i_frame_active = 1'b1;
        tick();
        check_output("ovr_start",   {31'd0, o_overrun},   32'h0);
        apply_stimulus(8'h00);
        check_output("burst_rd_cs", {28'd0, o_cs},        32'h1);
        apply_stimulus(8'hEE);
        check_output("ovr_set",     {31'd0, o_overrun},   32'h1);
        tick();
        check_output("burst_txv",   {31'd0, o_tx_valid},  32'h1);
        check_output("burst_tx",    {24'd0, o_tx_byte},   32'h01);
        tick();
        check_output("burst_rd_idle", {31'd0, o_busy},    32'h0);
        apply_stimulus(8'hC3);
        apply_stimulus(8'h5A);
        check_output("burst_wr_cs", {28'd0, o_cs},        32'h4);
        check_output("burst_wr_ld", {31'd0, o_load_cmd},  32'h1);
        check_output("burst_wr_ioc", {27'd0, o_ioc},      32'h3);
        check_output("burst_wr_dat", {24'd0, o_data_out}, 32'h5A);
        tick();
        check_output("ovr_sticky",  {31'd0, o_overrun},   32'h1);
        i_frame_active = 1'b0;
        tick();
        check_output("ovr_low_frame", {31'd0, o_overrun}, 32'h1);
        i_frame_active = 1'b1;
        tick();
        check_output("ovr_clear",   {31'd0, o_overrun},   32'h0);

        // Asynchronous reset while the load strobe is high
        apply_stimulus(8'h84);
        apply_stimulus(8'h77);
        check_output("pre_rst_load", {31'd0, o_load_cmd}, 32'h1);
        i_rst_b = 1'b0;
        #1;
        check_output("arst_load",   {31'd0, o_load_cmd},  32'h0);
        check_output("arst_cs",     {28'd0, o_cs},        32'h0);
        check_output("arst_busy",   {31'd0, o_busy},      32'h0);
        check_output("arst_ioc",    {27'd0, o_ioc},       32'h0);
        check_output("arst_data",   {24'd0, o_data_out},  32'h00);
        check_output("arst_tx",     {24'd0, o_tx_byte},   32'h00);
        #1;
        i_rst_b = 1'b1;
        tick();
        check_output("post_rst_busy", {31'd0, o_busy},    32'h0);
        apply_stimulus(8'h02);
        check_output("post_rst_rd_cs", {28'd0, o_cs},     32'h1);
        check_output("post_rst_ioc", {27'd0, o_ioc},      32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
